// File: rtl/pilha_pkg.sv
// pilha_pkg -- shared definitions for the pilha stack.
//   LARGURA_PADRAO / PROFUNDIDADE_PADRAO : default word width and depth
//   cmd_t                                : controle_pilha encoding (PUSH=1, POP=0)
//   nivel_largura()                      : bits needed for an entry count 0..depth
package pilha_pkg;

  localparam int LARGURA_PADRAO      = 16;
  localparam int PROFUNDIDADE_PADRAO = 16;

  typedef enum logic {
    POP  = 1'b0,
    PUSH = 1'b1
  } cmd_t;

  // One extra bit so the count can reach the depth itself.
  function automatic int nivel_largura(input int profundidade);
    return $clog2(profundidade) + 1;
  endfunction

endpackage

// File: rtl/pilha_mem.sv
// pilha_mem -- stack storage: synchronous-write register file with two
// combinational read ports. Contents are not reset.
//   clock    : write clock
//   escreve  : write enable
//   end_esc  : write address
//   dado     : write data
//   end_rd1  : read port 1 address -> dado_rd1
//   end_rd2  : read port 2 address -> dado_rd2
module pilha_mem #(
  parameter int LARGURA      = 16,
  parameter int PROFUNDIDADE = 16,
  parameter int LARG_END     = $clog2(PROFUNDIDADE)
) (
  input  logic                clock,
  input  logic                escreve,
  input  logic [LARG_END-1:0] end_esc,
  input  logic [LARGURA-1:0]  dado,
  input  logic [LARG_END-1:0] end_rd1,
  input  logic [LARG_END-1:0] end_rd2,
  output logic [LARGURA-1:0]  dado_rd1,
  output logic [LARGURA-1:0]  dado_rd2
);

  logic [LARGURA-1:0] mem [PROFUNDIDADE];

  always_ff @(posedge clock) begin
    if (escreve) begin
      mem[end_esc] <= dado;
    end
  end

  assign dado_rd1 = mem[end_rd1];
  assign dado_rd2 = mem[end_rd2];

endmodule

// File: rtl/pilha.sv
// pilha -- LIFO operand stack with registered top/second outputs.
//   clock          : clock, rising edge
//   reset          : synchronous active-high reset, wins over any command
//   pilha_wren     : command strobe
//   controle_pilha : 1 = push, 0 = pop
//   data_pilha     : word to push
//   topo, segundo  : top and second entries (0 when absent)
//   nivel          : entry count 0..PROFUNDIDADE
//   vazia, cheia   : empty / full
//   erro_overflow, erro_underflow : sticky error flags until reset
// Optional feature: define PILHA_ERRO_EN to build the error flags; otherwise
// both error ports are constant 0. Illegal commands are ignored either way.
module pilha
  import pilha_pkg::*;
#(
  parameter int LARGURA      = LARGURA_PADRAO,
  parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     pilha_wren,
  input  logic                                     controle_pilha,
  input  logic [LARGURA-1:0]                       data_pilha,
  output logic [LARGURA-1:0]                       topo,
  output logic [LARGURA-1:0]                       segundo,
  output logic [nivel_largura(PROFUNDIDADE)-1:0]   nivel,
  output logic                                     vazia,
  output logic                                     cheia,
  output logic                                     erro_overflow,
  output logic                                     erro_underflow
);

  localparam int NW = nivel_largura(PROFUNDIDADE);
  localparam int AW = $clog2(PROFUNDIDADE);

  logic [NW-1:0]      sp;
  logic [NW-1:0]      sp_prox;
  logic               push_ok;
  logic               pop_ok;
  logic [AW-1:0]      end_rd1;
  logic [AW-1:0]      end_rd2;
  logic [LARGURA-1:0] dado_rd1;
  logic [LARGURA-1:0] dado_rd2;
  logic [LARGURA-1:0] topo_prox;
  logic [LARGURA-1:0] segundo_prox;

  assign push_ok = !reset && pilha_wren && (controle_pilha == PUSH) && !cheia;
  assign pop_ok  = !reset && pilha_wren && (controle_pilha == POP)  && !vazia;

  always_comb begin
    sp_prox = sp;
    if (push_ok) begin
      sp_prox = sp + NW'(1);
    end else if (pop_ok) begin
      sp_prox = sp - NW'(1);
    end
  end

  // Read ports look ahead at the post-command pointer so topo/segundo can be
  // registered at the same edge as the command. Modulo arithmetic on the low
  // bits is fine: results are only used when sp_prox is large enough.
  assign end_rd1 = sp_prox[AW-1:0] - AW'(1);
  assign end_rd2 = sp_prox[AW-1:0] - AW'(2);

  // On a push the new top is not in memory yet, so take it from the input;
  // the old top (mem[sp-1] == mem[sp_prox-2]) becomes the second.
  always_comb begin
    topo_prox    = '0;
    segundo_prox = '0;
    if (push_ok) begin
      topo_prox = data_pilha;
    end else if (sp_prox != '0) begin
      topo_prox = dado_rd1;
    end
    if (sp_prox >= NW'(2)) begin
      segundo_prox = dado_rd2;
    end
  end

  pilha_mem #(
    .LARGURA      (LARGURA),
    .PROFUNDIDADE (PROFUNDIDADE),
    .LARG_END     (AW)
  ) u_mem (
    .clock    (clock),
    .escreve  (push_ok),
    .end_esc  (sp[AW-1:0]),
    .dado     (data_pilha),
    .end_rd1  (end_rd1),
    .end_rd2  (end_rd2),
    .dado_rd1 (dado_rd1),
    .dado_rd2 (dado_rd2)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      sp      <= '0;
      topo    <= '0;
      segundo <= '0;
      vazia   <= 1'b1;
      cheia   <= 1'b0;
    end else if (pilha_wren) begin
      sp      <= sp_prox;
      topo    <= topo_prox;
      segundo <= segundo_prox;
      vazia   <= (sp_prox == '0);
      cheia   <= (sp_prox == NW'(PROFUNDIDADE));
    end
  end

  assign nivel = sp;

`ifdef PILHA_ERRO_EN
  logic erro_ov_q;
  logic erro_un_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      erro_ov_q <= 1'b0;
      erro_un_q <= 1'b0;
    end else begin
      if (pilha_wren && (controle_pilha == PUSH) && cheia) erro_ov_q <= 1'b1;
      if (pilha_wren && (controle_pilha == POP)  && vazia) erro_un_q <= 1'b1;
    end
  end

  assign erro_overflow  = erro_ov_q;
  assign erro_underflow = erro_un_q;
`else
  assign erro_overflow  = 1'b0;
  assign erro_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_pilha.sv
module tb_pilha;
  import pilha_pkg::*;

  localparam int L  = 16;
  localparam int P  = 16;
  localparam int NW = nivel_largura(P);

  logic          clock = 1'b0;
  logic          reset;
  logic          pilha_wren;
  logic          controle_pilha;
  logic [L-1:0]  data_pilha;
  logic [L-1:0]  topo;
  logic [L-1:0]  segundo;
  logic [NW-1:0] nivel;
  logic          vazia;
  logic          cheia;
  logic          erro_overflow;
  logic          erro_underflow;

  pilha #(.LARGURA(L), .PROFUNDIDADE(P)) dut (
    .clock          (clock),
    .reset          (reset),
    .pilha_wren     (pilha_wren),
    .controle_pilha (controle_pilha),
    .data_pilha     (data_pilha),
    .topo           (topo),
    .segundo        (segundo),
    .nivel          (nivel),
    .vazia          (vazia),
    .cheia          (cheia),
    .erro_overflow  (erro_overflow),
    .erro_underflow (erro_underflow)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a plain queue, back = top of stack.
  logic [L-1:0] q[$];
  logic         m_ov = 1'b0;
  logic         m_un = 1'b0;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nome, got, exp);
    end
  endtask

  task automatic modelo(input logic r, input logic w, input logic c, input logic [L-1:0] d);
    if (r) begin
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else if (w) begin
      if (c) begin
        if (q.size() < P) q.push_back(d);
        else m_ov = 1'b1;
      end else begin
        if (q.size() > 0) void'(q.pop_back());
        else m_un = 1'b1;
      end
    end
  endtask

  // Drive at the falling edge, let the rising edge sample, then settle.
  task automatic passo(input logic r, input logic w, input logic c, input logic [L-1:0] d);
    @(negedge clock);
    reset = r; pilha_wren = w; controle_pilha = c; data_pilha = d;
    @(posedge clock);
    modelo(r, w, c, d);
    #2;
  endtask

  task automatic confere(input string tag);
    int n;
    logic [L-1:0] et, es;
    logic eov, eun;
    n  = q.size();
    et = (n >= 1) ? q[n-1] : '0;
    es = (n >= 2) ? q[n-2] : '0;
`ifdef PILHA_ERRO_EN
    eov = m_ov; eun = m_un;
`else
    eov = 1'b0; eun = 1'b0;
`endif
    chk({tag, ".topo"},    32'(topo),    32'(et));
    chk({tag, ".segundo"}, 32'(segundo), 32'(es));
    chk({tag, ".nivel"},   32'(nivel),   32'(n));
    chk({tag, ".vazia"},   32'(vazia),   32'(n == 0));
    chk({tag, ".cheia"},   32'(cheia),   32'(n == P));
    chk({tag, ".ovf"},     32'(erro_overflow),  32'(eov));
    chk({tag, ".unf"},     32'(erro_underflow), 32'(eun));
  endtask

  typedef struct {
    logic         r, w, c;
    logic [L-1:0] d;
    logic [L-1:0] e_topo, e_seg;
    int           e_niv;
    logic         e_vaz;
  } vetor_t;

  vetor_t tab[6];
  int     bias;

  initial begin
    reset = 1'b1; pilha_wren = 1'b0; controle_pilha = 1'b0; data_pilha = '0;

    tab[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0, 1'b1};
    tab[1] = '{1'b0, 1'b1, 1'b1, 16'h0005, 16'h0005, 16'h0000, 1, 1'b0};
    tab[2] = '{1'b0, 1'b1, 1'b1, 16'h0007, 16'h0007, 16'h0005, 2, 1'b0};
    tab[3] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0005, 16'h0000, 1, 1'b0};
    tab[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0, 1'b1};
    tab[5] = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 0, 1'b1};

    for (int i = 0; i < 6; i++) begin
      passo(tab[i].r, tab[i].w, tab[i].c, tab[i].d);
      chk($sformatf("tab%0d.topo", i),    32'(topo),    32'(tab[i].e_topo));
      chk($sformatf("tab%0d.segundo", i), 32'(segundo), 32'(tab[i].e_seg));
      chk($sformatf("tab%0d.nivel", i),   32'(nivel),   32'(tab[i].e_niv));
      chk($sformatf("tab%0d.vazia", i),   32'(vazia),   32'(tab[i].e_vaz));
      confere($sformatf("tab%0d", i));
    end

    // Fill to capacity, then push once more while full.
    for (int i = 1; i <= P; i++) passo(1'b0, 1'b1, 1'b1, L'(i));
    chk("cheio.cheia", 32'(cheia), 32'd1);
    chk("cheio.topo",  32'(topo),  32'h0010);
    passo(1'b0, 1'b1, 1'b1, 16'hFFFF);
    chk("ovf.topo",  32'(topo),  32'h0010);
    chk("ovf.nivel", 32'(nivel), 32'd16);
`ifdef PILHA_ERRO_EN
    chk("ovf.flag", 32'(erro_overflow), 32'd1);
`else
    chk("ovf.flag", 32'(erro_overflow), 32'd0);
`endif
    confere("ovf");

    // Pop back down and past empty.
    for (int i = 0; i < P; i++) begin
      passo(1'b0, 1'b1, 1'b0, '0);
      confere("desce");
    end
    passo(1'b0, 1'b1, 1'b0, '0);
    chk("unf.nivel", 32'(nivel), 32'd0);
    chk("unf.topo",  32'(topo),  32'd0);
`ifdef PILHA_ERRO_EN
    chk("unf.flag", 32'(erro_underflow), 32'd1);
`else
    chk("unf.flag", 32'(erro_underflow), 32'd0);
`endif
    confere("unf");

    // Reset coincident with a push at nivel 3.
    for (int i = 0; i < 3; i++) passo(1'b0, 1'b1, 1'b1, L'(16'h00A0 + i));
    chk("pre_rst.nivel", 32'(nivel), 32'd3);
    passo(1'b1, 1'b1, 1'b1, 16'h1234);
    chk("rst_push.nivel", 32'(nivel), 32'd0);
    chk("rst_push.topo",  32'(topo),  32'd0);
    chk("rst_push.ovf",   32'(erro_overflow),  32'd0);
    chk("rst_push.unf",   32'(erro_underflow), 32'd0);
    confere("rst_push");

    // Hold with the strobe low while other inputs toggle.
    passo(1'b0, 1'b1, 1'b1, 16'h0B0B);
    passo(1'b0, 1'b1, 1'b1, 16'h0C0C);
    for (int i = 0; i < 10; i++) begin
      passo(1'b0, 1'b0, 1'(i), L'($urandom));
      chk("hold.topo",    32'(topo),    32'h0C0C);
      chk("hold.segundo", 32'(segundo), 32'h0B0B);
      chk("hold.nivel",   32'(nivel),   32'd2);
    end

    // Randomized traffic with drifting push/pop bias to visit full and empty.
    for (int i = 0; i < 1500; i++) begin
      case ((i / 100) % 3)
        0: bias = 80;
        1: bias = 20;
        default: bias = 50;
      endcase
      passo(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 99) < bias),
            L'($urandom));
      confere("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
